in_module: RTL and testbench
============================

# in_module

Operator-entry block for the board front panel: reads a decimal digit from four switches, a sign switch and three push-buttons, then builds a signed 33-bit two's-complement operand. It delivers the operand to the datapath with a valid/ack handshake. It is the input counterpart of the binary-to-BCD/7-segment output path; the live entry can be echoed to that path.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a button level is accepted. The board build overrides it with 500000.
- MAX_DIGITS, 3: maximum decimal digits per operand. Legal range is 1..9.
- clock  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- digit_in  in  4  BCD digit from switches; asynchronous, sampled through a 2-FF synchronizer.
- sign_in  in  1  sign switch, 1 = negative; synchronized the same way.
- enter_btn  in  1  raw button, active-high: append the current digit.
- done_btn  in  1  raw button, active-high: commit the operand.
- clear_btn  in  1  raw button, active-high: abandon the current entry.
- value_out  out  33  committed operand, two's complement.
- valid  out  1  value_out holds a committed operand.
- ack  in  1  consumer accepts value_out.
- digit_count  out  4  number of digits entered so far.
- err  out  1  one-cycle pulse when a digit is rejected.

## Operation
- Reset values: value_out=0, valid=0, digit_count=0, err=0, accumulator=0, state=IDLE.
- Each raw button passes through a 2-FF synchronizer, then the debouncer, then a rising-edge detector. The result is a one-cycle press pulse.
- Internal accumulator: 32-bit unsigned. Digit update is acc <= acc*10 + digit, computed as (acc<<3)+(acc<<1)+digit.
- FSM states:
  - IDLE: digit_count=0. An enter pulse with a legal digit goes to ENTRY.
  - ENTRY: collecting digits.
  - HOLD: valid=1; waiting for ack.
- Enter pulse in IDLE or ENTRY:
  - digit_in>9: err pulses, no state change.
  - digit_count==MAX_DIGITS: err pulses, no state change.
  - Otherwise: accumulator updates and digit_count increments.
- Done pulse in IDLE or ENTRY:
  - value_out <= sign_in ? -{1'b0,acc} : {1'b0,acc}. sign_in is sampled in the cycle of the pulse.
  - Then valid<=1 and the FSM goes to HOLD.
  - Done in IDLE commits 0. A negative zero is output as 0.
- HOLD:
  - enter and done pulses are ignored.
  - When valid&&ack is sampled, valid=0 and accumulator/digit_count=0 on the next edge, and the FSM returns to IDLE.
  - value_out keeps its last value after the handshake.
- Clear pulse, any state: accumulator=0, digit_count=0, valid=0, state=IDLE.
- Simultaneous pulses in the same cycle: clear wins over done, and done wins over enter. The enter digit is discarded.
- ack outside HOLD is ignored.
- reset_n low mid-entry or mid-HOLD: immediate return to the reset values. Debouncer counters and synchronizers are cleared to 0, meaning released.

## Timing
- Press pulse: exactly one cycle wide per accepted press. It asserts 2 to DEBOUNCE_CYCLES+3 edges after the raw level goes high and stays stable.
- Any bounce that returns before DEBOUNCE_CYCLES stable cycles restarts the count and produces no pulse.
- The release edge must also debounce before another press can register.
- Enter pulse to digit_count/accumulator update: 1 edge.
- Done pulse to valid high with value_out valid: 1 edge.
- err is high for exactly the cycle after the rejected pulse.
- valid stays high until ack is sampled high; the earliest deassertion is the edge after ack.
- digit_count and value_out are registered outputs with no combinational paths from inputs.

## Configuration
- IN_MODULE_DEBOUNCE_EN:
  - Defined: the full debouncer is instantiated and DEBOUNCE_CYCLES applies.
  - Undefined: the debouncer is bypassed, and buttons are treated as clean after the 2-FF synchronizer. The press pulse then asserts exactly 3 edges after the raw rise. This build is for simulation and fast benches.
- FSM behaviour is identical in both builds.

## Structure
- Shared package in_module_pkg:
  - FSM state encoding (IDLE, ENTRY, HOLD).
  - VALUE_W=33 and ACC_W=32.
  - BCD_MAX=9.
- One sub-module, debouncer, instantiated three times (enter, done, clear):
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: clock, reset_n, raw, press.
  - Contains the synchronizer, counter and edge detect.
- The multiply-by-10 accumulation and the sign negation stay inline in in_module.

## Test plan
- Digits 1,2,3 entered, sign_in=0, done: value_out=33'd123, valid=1 until ack. valid=0 one edge after ack; digit_count=0.
- Digits 4,5 entered, sign_in=1, done: value_out=33'h1_FFFF_FFD3 (-45), digit_count=2 before commit.
- digit_in=4'hA then enter: err high for one cycle, digit_count unchanged. A subsequent valid digit is accepted normally.
- MAX_DIGITS=3, digits 9,9,9,7: the fourth enter pulses err. done gives value_out=999.
- enter_btn bounced with five pulses of 3 cycles each, then held for DEBOUNCE_CYCLES+5 cycles (DEBOUNCE_EN defined): exactly one digit accepted, digit_count=1.
- Two cases that must both leave valid=0, digit_count=0, state IDLE:
  - clear asserted during HOLD, with ack never given.
  - reset_n pulsed low mid-entry after 2 digits. In this case value_out must also be 0.

Source files
------------

// File: rtl/in_module_pkg.sv
// ============================================================================
//  in_module_pkg
//  Shared types and constants for the front-panel operand entry block.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package in_module_pkg;

    localparam int VALUE_W = 33;
    localparam int ACC_W   = 32;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/in_module_debouncer.sv
// ============================================================================
//  debouncer
//  Synchronizer, debounce counter and rising-edge detect for one raw button.
//  Full debounce only when IN_MODULE_DEBOUNCE_EN is defined.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module debouncer
    import in_module_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic press
);

`ifdef IN_MODULE_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    logic sync1_q, sync2_q;
    logic level_q, level_d;
    logic press_q, press_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press_d = level_d & ~level_q;
    assign press   = press_q;

    generate
        if (DEB_EN && (DEBOUNCE_CYCLES > 0)) begin : g_debounce
            localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            always_comb begin
                cnt_d   = cnt_q;
                level_d = level_q;
                if (sync2_q == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    level_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_bypass
            assign level_d = sync2_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/in_module.sv
// ============================================================================
//  in_module
//  Front-panel decimal operand entry with valid/ack delivery.
//  Debouncing controlled by IN_MODULE_DEBOUNCE_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module in_module
    import in_module_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_DIGITS      = 3
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [3:0]   digit_in,
    input  logic         sign_in,
    input  logic         enter_btn,
    input  logic         done_btn,
    input  logic         clear_btn,
    output logic [32:0]  value_out,
    output logic         valid,
    input  logic         ack,
    output logic [3:0]   digit_count,
    output logic         err
);

    logic enter_press, done_press, clear_press;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clock(clock), .reset_n(reset_n), .raw(enter_btn), .press(enter_press));
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_done (
        .clock(clock), .reset_n(reset_n), .raw(done_btn), .press(done_press));
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clock(clock), .reset_n(reset_n), .raw(clear_btn), .press(clear_press));

    logic [3:0]         digit_s1_q, digit_s2_q;
    logic               sign_s1_q, sign_s2_q;
    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [3:0]         count_q, count_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    // Priority: clear > done > enter; HOLD ignores enter/done.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        value_d = value_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        if (clear_press) begin
            acc_d   = '0;
            count_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, ENTRY: begin
                    if (done_press) begin
                        value_d = sign_s2_q ? (VALUE_W'(0) - {1'b0, acc_q}) : {1'b0, acc_q};
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else if (enter_press) begin
                        if ((digit_s2_q > BCD_MAX) || (count_q == 4'(MAX_DIGITS))) begin
                            err_d = 1'b1;
                        end else begin
                            acc_d   = (acc_q << 3) + (acc_q << 1) + ACC_W'(digit_s2_q);
                            count_d = count_q + 4'd1;
                            state_d = ENTRY;
                        end
                    end
                end
                HOLD: begin
                    if (valid_q && ack) begin
                        valid_d = 1'b0;
                        acc_d   = '0;
                        count_d = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit_s1_q <= '0;
            digit_s2_q <= '0;
            sign_s1_q  <= 1'b0;
            sign_s2_q  <= 1'b0;
            state_q    <= IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            digit_s1_q <= digit_in;
            digit_s2_q <= digit_s1_q;
            sign_s1_q  <= sign_in;
            sign_s2_q  <= sign_s1_q;
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign value_out   = value_q;
    assign valid       = valid_q;
    assign digit_count = count_q;
    assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_in_module.sv
// ============================================================================
//  tb_in_module
//  Directed self-checking bench for in_module.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_in_module;
    import in_module_pkg::*;

    localparam int DC = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  digit_in;
    logic        sign_in;
    logic        enter_btn, done_btn, clear_btn;
    logic [32:0] value_out;
    logic        valid;
    logic        ack;
    logic [3:0]  digit_count;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    int err_base;

    in_module #(.DEBOUNCE_CYCLES(DC), .MAX_DIGITS(3)) dut (
        .clock(clock), .reset_n(reset_n), .digit_in(digit_in), .sign_in(sign_in),
        .enter_btn(enter_btn), .done_btn(done_btn), .clear_btn(clear_btn),
        .value_out(value_out), .valid(valid), .ack(ack),
        .digit_count(digit_count), .err(err));

    always #5 clock = ~clock;

    always @(negedge clock) if (err === 1'b1) err_cnt++;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0 = enter, 1 = done, 2 = clear; long enough to debounce press and release.
    task automatic press(input int which);
        @(negedge clock);
        case (which)
            0: enter_btn = 1'b1;
            1: done_btn  = 1'b1;
            default: clear_btn = 1'b1;
        endcase
        repeat (DC + 8) @(negedge clock);
        enter_btn = 1'b0;
        done_btn  = 1'b0;
        clear_btn = 1'b0;
        repeat (DC + 8) @(negedge clock);
    endtask

    task automatic enter_digit(input logic [3:0] d);
        digit_in = d;
        press(0);
    endtask

    task automatic do_ack();
        @(negedge clock);
        ack = 1'b1;
        @(posedge clock);
        #1;
        ack = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; digit_in = 4'd0; sign_in = 1'b0; ack = 1'b0;
        enter_btn = 1'b0; done_btn = 1'b0; clear_btn = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_value", value_out, 33'd0);
        chk("rst_valid", {32'd0, valid}, 33'd0);
        chk("rst_count", {29'd0, digit_count}, 33'd0);
        chk("rst_err", {32'd0, err}, 33'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // 1,2,3 positive
        enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3);
        chk("t1_count", {29'd0, digit_count}, 33'd3);
        sign_in = 1'b0;
        press(1);
        chk("t1_valid", {32'd0, valid}, 33'd1);
        chk("t1_value", value_out, 33'd123);
        repeat (5) @(negedge clock);
        chk("t1_valid_hold", {32'd0, valid}, 33'd1);
        do_ack();
        chk("t1_valid_after_ack", {32'd0, valid}, 33'd0);
        chk("t1_count_after_ack", {29'd0, digit_count}, 33'd0);
        chk("t1_value_kept", value_out, 33'd123);

        // 4,5 negative
        enter_digit(4'd4); enter_digit(4'd5);
        chk("t2_count", {29'd0, digit_count}, 33'd2);
        sign_in = 1'b1;
        press(1);
        chk("t2_value", value_out, 33'h1_FFFF_FFD3);
        chk("t2_valid", {32'd0, valid}, 33'd1);
        do_ack();
        sign_in = 1'b0;

        // illegal digit then a legal one
        err_base = err_cnt;
        enter_digit(4'hA);
        chk("t3_err_pulse", 33'(err_cnt - err_base), 33'd1);
        chk("t3_count", {29'd0, digit_count}, 33'd0);
        enter_digit(4'd7);
        chk("t3_count_ok", {29'd0, digit_count}, 33'd1);
        press(1);
        chk("t3_value", value_out, 33'd7);
        do_ack();

        // overflow of MAX_DIGITS
        enter_digit(4'd9); enter_digit(4'd9); enter_digit(4'd9);
        err_base = err_cnt;
        enter_digit(4'd7);
        chk("t4_err_pulse", 33'(err_cnt - err_base), 33'd1);
        chk("t4_count", {29'd0, digit_count}, 33'd3);
        press(1);
        chk("t4_value", value_out, 33'd999);
        do_ack();

`ifdef IN_MODULE_DEBOUNCE_EN
        // bouncing enter: exactly one accepted digit
        digit_in = 4'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); enter_btn = 1'b1;
            repeat (3) @(negedge clock); enter_btn = 1'b0;
            repeat (3) @(negedge clock);
        end
        enter_btn = 1'b1;
        repeat (DC + 5) @(negedge clock);
        enter_btn = 1'b0;
        repeat (DC + 8) @(negedge clock);
        chk("t5_bounce_count", {29'd0, digit_count}, 33'd1);
        press(2);
`endif

        // clear during HOLD, no ack
        enter_digit(4'd5);
        press(1);
        chk("t6_valid_hold", {32'd0, valid}, 33'd1);
        press(2);
        chk("t6_valid", {32'd0, valid}, 33'd0);
        chk("t6_count", {29'd0, digit_count}, 33'd0);
        chk("t6_state", {31'd0, dut.state_q}, {31'd0, IDLE});

        // reset mid-entry
        enter_digit(4'd1); enter_digit(4'd2);
        chk("t7_count_pre", {29'd0, digit_count}, 33'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("t7_value", value_out, 33'd0);
        chk("t7_valid", {32'd0, valid}, 33'd0);
        chk("t7_count", {29'd0, digit_count}, 33'd0);
        chk("t7_state", {31'd0, dut.state_q}, {31'd0, IDLE});
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // done in IDLE with sign set: negative zero commits 0
        sign_in = 1'b1;
        press(1);
        chk("t8_valid", {32'd0, valid}, 33'd1);
        chk("t8_value", value_out, 33'd0);
        do_ack();
        chk("t8_valid_after_ack", {32'd0, valid}, 33'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
